spi_host: RTL and testbench

Host-side (master) SPI engine driving the 7-bit-address / R-W / 16-bit-data frame that `spi_slave` serves. It accepts a single-word read or write request from on-chip logic, then generates `csz`, `sclk`, and `sdi`. It samples `sdo` and returns read data with a one-cycle `done` pulse. It is the test and bring-up initiator for `spi_slave`/`spi_mem` and sits between a register/bus agent and the SPI pins.

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_host_if.sv | 28 ++
 rtl/spi_sclk_gen.sv | 39 +++
 rtl/spi_host.sv | 157 +++++++++++++++
 tb/tb_spi_host.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI host: frame geometry, R/W encoding,
// FSM state enum and a helper that assembles the 24-bit outgoing frame.
package spi_pkg;

  localparam int   SPI_ADDR_W     = 7;
  localparam int   SPI_DATA_W     = 16;
  localparam int   SPI_FRAME_BITS = 24;
  localparam logic SPI_RW_READ    = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    GAP
  } spi_host_state_t;

  // Reads drive all-ones in the data phase so the slave sees an idle-high line.
  function automatic logic [SPI_FRAME_BITS-1:0] spi_build_frame(
    input logic [SPI_ADDR_W-1:0] addr,
    input logic                  rwb,
    input logic [SPI_DATA_W-1:0] wdata
  );
    return {addr, rwb, (rwb == SPI_RW_READ) ? {SPI_DATA_W{1'b1}} : wdata};
  endfunction

endpackage

// File: rtl/spi_host_if.sv
// Request/response and SPI pin bundle for spi_host; the master modport is the
// host engine, the slave modport is the agent/pin side facing it.
interface spi_host_if import spi_pkg::*; ();

  logic                  start;
  logic                  rwb;
  logic [SPI_ADDR_W-1:0] addr;
  logic [SPI_DATA_W-1:0] wdata;
  logic                  busy;
  logic                  done;
  logic [SPI_DATA_W-1:0] rdata;
  logic                  mismatch;
  logic                  csz;
  logic                  sclk;
  logic                  sdi;
  logic                  sdo;

  modport master (
    input  start, rwb, addr, wdata, sdo,
    output busy, done, rdata, mismatch, csz, sclk, sdi
  );

  modport slave (
    output start, rwb, addr, wdata, sdo,
    input  busy, done, rdata, mismatch, csz, sclk, sdi
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// SPI clock divider: CLK_DIV clk cycles per sclk half-period, with rise/fall
// strobes in the cycle before sclk changes; sclk is held low while disabled.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_cnt;
  logic             r_sclk;
  logic             w_half_end;

  assign w_half_end = i_en && (r_cnt == DIV_LAST);
  assign o_rise     = w_half_end && !r_sclk;
  assign o_fall     = w_half_end && r_sclk;
  assign o_sclk     = r_sclk;

  // NOTE: sequential state uses <= so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || !i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_half_end) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_host.sv
// SPI master for the 7-bit addr / R-W / 16-bit data frame. Optional feature
// SPI_HOST_WRITE_VERIFY_EN: every write is read back and compared.
module spi_host import spi_pkg::*; #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input logic        clk,
  input logic        reset,
  spi_host_if.master bus
);

  localparam int               WAIT_MAX  = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int               WAIT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WAIT_W-1:0] HOLD_LAST = WAIT_W'(CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] GAP_LAST  = WAIT_W'(CS_GAP - 1);
  localparam logic [4:0]        BIT_LAST  = 5'(SPI_FRAME_BITS - 1);
  localparam logic [4:0]        BIT_DATA0 = 5'(SPI_ADDR_W + 1);

  spi_host_state_t           r_state, w_state_next;
  logic [4:0]                r_bit;
  logic [WAIT_W-1:0]         r_wait;
  logic                      r_rwb;
  logic [SPI_FRAME_BITS-1:0] r_tx, w_frame;
  logic [SPI_DATA_W-1:0]     r_rx, r_rdata;
  logic                      r_csz, r_sdi, r_busy, r_done, r_mismatch;
  logic                      w_sclk, w_rise, w_fall;
  logic                      w_accept, w_shift_end, w_hold_end, w_gap_end;
  logic                      w_verify_next, w_mismatch_next, w_finish, w_load;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk    (clk),
    .reset  (reset),
    .i_en   (r_state == SHIFT),
    .o_sclk (w_sclk),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_accept    = (r_state == IDLE) && bus.start;
  assign w_shift_end = w_fall && (r_bit == BIT_LAST);
  assign w_hold_end  = (r_state == HOLD) && (r_wait == HOLD_LAST);
  assign w_gap_end   = (r_state == GAP) && (r_wait == GAP_LAST);
  assign w_load      = w_accept || w_verify_next;

`ifdef SPI_HOST_WRITE_VERIFY_EN
  logic                  r_verify;
  logic [SPI_ADDR_W-1:0] r_addr;
  logic [SPI_DATA_W-1:0] r_cmp;

  // The readback frame is itself a read, so it cannot trigger another one.
  assign w_verify_next   = w_gap_end && (r_rwb != SPI_RW_READ);
  assign w_frame         = w_verify_next ? spi_build_frame(r_addr, SPI_RW_READ, r_cmp)
                                         : spi_build_frame(bus.addr, bus.rwb, bus.wdata);
  assign w_mismatch_next = r_verify && (r_rx != r_cmp);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_verify <= 1'b0;
      r_addr   <= '0;
      r_cmp    <= '0;
    end else if (w_accept) begin
      r_verify <= 1'b0;
      r_addr   <= bus.addr;
      r_cmp    <= bus.wdata;
    end else if (w_verify_next) begin
      r_verify <= 1'b1;
    end
  end
`else
  assign w_verify_next   = 1'b0;
  assign w_frame         = spi_build_frame(bus.addr, bus.rwb, bus.wdata);
  assign w_mismatch_next = 1'b0;
`endif

  // NOTE: defaults first so no path through the case infers a latch.
  always_comb begin
    w_state_next = r_state;
    w_finish     = 1'b0;
    case (r_state)
      IDLE:  if (w_accept) w_state_next = SHIFT;
      SHIFT: if (w_shift_end) w_state_next = HOLD;
      HOLD:  if (w_hold_end) w_state_next = GAP;
      GAP: begin
        if (w_gap_end) begin
          if (w_verify_next) begin
            w_state_next = SHIFT;
          end else begin
            w_state_next = IDLE;
            w_finish     = 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_bit      <= '0;
      r_wait     <= '0;
      r_rwb      <= 1'b0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rdata    <= '0;
      r_csz      <= 1'b1;
      r_sdi      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_done     <= w_finish;
      r_mismatch <= w_finish && w_mismatch_next;

      if ((r_state == HOLD) || (r_state == GAP)) begin
        r_wait <= (w_hold_end || w_gap_end) ? '0 : r_wait + 1'b1;
      end else begin
        r_wait <= '0;
      end

      // sdi only moves at the start of a low half: on load or on an sclk fall.
      if (w_load) begin
        r_bit <= '0;
        r_csz <= 1'b0;
        r_sdi <= w_frame[SPI_FRAME_BITS-1];
        r_tx  <= {w_frame[SPI_FRAME_BITS-2:0], 1'b0};
        r_rwb <= w_accept ? bus.rwb : SPI_RW_READ;
      end else if (w_fall) begin
        if (r_bit == BIT_LAST) begin
          r_sdi <= 1'b1;
        end else begin
          r_bit <= r_bit + 1'b1;
          r_sdi <= r_tx[SPI_FRAME_BITS-1];
          r_tx  <= {r_tx[SPI_FRAME_BITS-2:0], 1'b0};
        end
      end

      if (w_rise && (r_bit >= BIT_DATA0)) r_rx <= {r_rx[SPI_DATA_W-2:0], bus.sdo};
      if (w_hold_end) r_csz <= 1'b1;

      if (w_accept) r_busy <= 1'b1;
      else if (w_finish) r_busy <= 1'b0;

      if (w_finish && (r_rwb == SPI_RW_READ)) r_rdata <= r_rx;
    end
  end

  assign bus.csz      = r_csz;
  assign bus.sclk     = w_sclk;
  assign bus.sdi      = r_sdi;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.rdata    = r_rdata;
  assign bus.mismatch = r_mismatch;

endmodule

// File: tb/tb_spi_host.sv
// Self-checking bench for spi_host: a behavioural slave/monitor decodes frames
// from the pins, and expected timing and data come from the frame rules.
module tb_spi_host;

  localparam int D_A     = 2;
  localparam int G_A     = 4;
  localparam int FRAME_A = 49 * D_A;
`ifdef SPI_HOST_WRITE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  typedef struct {
    int          rises;
    int          low_cycles;
    logic [23:0] bits;
  } frame_t;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  int          cyc        = 0;
  int          n_checks   = 0;
  int          n_fail     = 0;
  logic [15:0] exp_rdata  = '0;
  logic [15:0] slave_word = 16'hFFFF;

  spi_host_if bus_a ();
  spi_host_if bus_b ();

  spi_host #(.CLK_DIV(D_A), .CS_GAP(G_A)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.master));
  spi_host #(.CLK_DIV(1),   .CS_GAP(1))   dut_b (.clk(clk), .reset(reset), .bus(bus_b.master));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model and frame monitor for dut_a: sdo presents data bit k during
  // frame bit 23-k, changing only after an observed sclk fall.
  frame_t frames[$];
  frame_t cur;
  int     fall_cnt  = 0;
  logic   prev_csz  = 1'b1;
  logic   prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (!bus_a.csz) begin
      if (prev_csz) begin
        cur.rises = 0; cur.low_cycles = 0; cur.bits = '0; fall_cnt = 0;
      end
      cur.low_cycles++;
      if (bus_a.sclk && !prev_sclk) begin
        cur.bits = {cur.bits[22:0], bus_a.sdi};
        cur.rises++;
      end
      if (!bus_a.sclk && prev_sclk) fall_cnt++;
    end else if (!prev_csz) begin
      frames.push_back(cur);
    end
    prev_csz  = bus_a.csz;
    prev_sclk = bus_a.sclk;
    bus_a.sdo = (!bus_a.csz && fall_cnt >= 8 && fall_cnt < 24) ? slave_word[23 - fall_cnt] : 1'b1;
  end

  task automatic wait_done(input int budget, input int pulse_at, input bit hold_start, output int d);
    d = -1;
    for (int t = 0; t < budget; t++) begin
      bus_a.start = hold_start || (cyc == pulse_at);
      @(negedge clk);
      if (bus_a.done) begin
        d = cyc;
        break;
      end
    end
  endtask

  task automatic at_done_checks(input string tag, input int n0, input int d, input logic rwb,
                                input logic [15:0] wdata, input logic [15:0] sw);
    bit two;
    int exp_d;
    two   = VERIFY && (rwb == 1'b0);
    exp_d = n0 + 1 + FRAME_A + G_A + (two ? FRAME_A + G_A : 0);
    if (rwb || two) exp_rdata = sw;
    check({tag, "/done_cycle"}, d, exp_d);
    check({tag, "/rdata"}, bus_a.rdata, exp_rdata);
    check({tag, "/mismatch"}, bus_a.mismatch, two && (sw != wdata));
    check({tag, "/busy_at_done"}, bus_a.busy, 0);
    check({tag, "/csz_at_done"}, bus_a.csz, 1);
    check({tag, "/sdi_idle"}, bus_a.sdi, 1);
    check({tag, "/sclk_idle"}, bus_a.sclk, 0);
  endtask

  task automatic frame_checks(input string tag, input logic rwb, input logic [6:0] addr,
                              input logic [15:0] wdata);
    int          nexp;
    logic [23:0] exp_bits;
    nexp = (VERIFY && (rwb == 1'b0)) ? 2 : 1;
    check({tag, "/n_frames"}, frames.size(), nexp);
    for (int i = 0; i < frames.size() && i < nexp; i++) begin
      exp_bits = (i == 0) ? {addr, rwb, rwb ? 16'hFFFF : wdata} : {addr, 1'b1, 16'hFFFF};
      check($sformatf("%s/f%0d_rises", tag, i), frames[i].rises, 24);
      check($sformatf("%s/f%0d_csz_low", tag, i), frames[i].low_cycles, FRAME_A);
      check($sformatf("%s/f%0d_sdi_bits", tag, i), frames[i].bits, exp_bits);
    end
  endtask

  task automatic launch(input string tag, input logic rwb, input logic [6:0] addr,
                        input logic [15:0] wdata, input bit keep_start, output int n0);
    bus_a.start = 1'b1; bus_a.rwb = rwb; bus_a.addr = addr; bus_a.wdata = wdata;
    n0 = cyc;
    @(negedge clk);
    bus_a.start = keep_start;
    bus_a.rwb = ~rwb; bus_a.addr = ~addr; bus_a.wdata = ~wdata;
    check({tag, "/first_csz"}, bus_a.csz, 0);
    check({tag, "/first_busy"}, bus_a.busy, 1);
    check({tag, "/first_sclk"}, bus_a.sclk, 0);
    check({tag, "/first_sdi"}, bus_a.sdi, addr[6]);
  endtask

  task automatic do_txn(input logic rwb, input logic [6:0] addr, input logic [15:0] wdata,
                        input logic [15:0] sw, input bit pulse, input string tag);
    int n0, d;
    frames.delete();
    slave_word = sw;
    @(negedge clk);
    launch(tag, rwb, addr, wdata, 1'b0, n0);
    wait_done(600, pulse ? n0 + 30 : -1, 1'b0, d);
    at_done_checks(tag, n0, d, rwb, wdata, sw);
    @(negedge clk);
    check({tag, "/done_pulse"}, bus_a.done, 0);
    check({tag, "/mismatch_pulse"}, bus_a.mismatch, 0);
    repeat (3) @(negedge clk);
    check({tag, "/no_restart"}, bus_a.csz, 1);
    frame_checks(tag, rwb, addr, wdata);
  endtask

  initial begin
    int n0, n1, d, dones;
    int low, tog, rises;
    logic prev_s, prev_low;
    logic rwb;
    logic [6:0] addr;
    logic [15:0] wdata, sw;

    bus_a.start = 1'b0; bus_a.rwb = 1'b0; bus_a.addr = '0; bus_a.wdata = '0;
    bus_b.start = 1'b0; bus_b.rwb = 1'b0; bus_b.addr = '0; bus_b.wdata = '0;
    bus_b.sdo   = 1'b1;

    repeat (3) @(negedge clk);
    check("rst/csz", bus_a.csz, 1);
    check("rst/sclk", bus_a.sclk, 0);
    check("rst/sdi", bus_a.sdi, 1);
    check("rst/busy", bus_a.busy, 0);
    check("rst/done", bus_a.done, 0);
    check("rst/rdata", bus_a.rdata, 0);
    check("rst/mismatch", bus_a.mismatch, 0);
    check("rst_b/csz", bus_b.csz, 1);
    check("rst_b/rdata", bus_b.rdata, 0);
    reset = 1'b0;

    // Reset in the middle of bit 10 of a read: frame abandoned, no done.
    @(negedge clk);
    frames.delete();
    slave_word = 16'hC3A5;
    launch("midrst", 1'b1, 7'h33, 16'h0000, 1'b0, n0);
    while (cyc < n0 + 1 + 20 * D_A + 1) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst/csz", bus_a.csz, 1);
    check("midrst/sclk", bus_a.sclk, 0);
    check("midrst/sdi", bus_a.sdi, 1);
    check("midrst/busy", bus_a.busy, 0);
    check("midrst/done", bus_a.done, 0);
    reset = 1'b0;
    dones = 0;
    for (int t = 0; t < 150; t++) begin
      @(negedge clk);
      if (bus_a.done) dones++;
    end
    check("midrst/no_done", dones, 0);
    check("midrst/rdata", bus_a.rdata, exp_rdata);
    check("midrst/stay_idle", bus_a.csz, 1);

    do_txn(1'b0, 7'h15, 16'hA5C3, 16'h0000, 1'b0, "wr15");
    do_txn(1'b1, 7'h7E, 16'h0000, 16'h1234, 1'b1, "rd7e");
    do_txn(1'b0, 7'h2C, 16'hBEEF, 16'hBEEF, 1'b0, "vfy_ok");
    do_txn(1'b0, 7'h2C, 16'hBEEF, 16'hBEEE, 1'b0, "vfy_bad");

    // Back-to-back: start held high through the done cycle of a write.
    frames.delete();
    slave_word = 16'h5A5A;
    @(negedge clk);
    launch("b2b1", 1'b0, 7'h2A, 16'h5A5A, 1'b1, n0);
    wait_done(600, -1, 1'b1, d);
    at_done_checks("b2b1", n0, d, 1'b0, 16'h5A5A, 16'h5A5A);
    frame_checks("b2b1", 1'b0, 7'h2A, 16'h5A5A);
    frames.delete();
    slave_word = 16'h9876;
    launch("b2b2", 1'b1, 7'h11, 16'h0000, 1'b0, n1);
    wait_done(600, -1, 1'b0, d);
    at_done_checks("b2b2", n1, d, 1'b1, 16'h0000, 16'h9876);
    @(negedge clk);
    frame_checks("b2b2", 1'b1, 7'h11, 16'h0000);

    for (int i = 0; i < 6; i++) begin
      rwb   = 1'($urandom_range(0, 1));
      addr  = 7'($urandom);
      wdata = 16'($urandom);
      sw    = ($urandom_range(0, 2) == 0) ? wdata : 16'($urandom);
      do_txn(rwb, addr, wdata, sw, i[0], $sformatf("rand%0d", i));
    end

    // Fastest configuration: sclk toggles every cycle, idle-high sdo reads 0xFFFF.
    @(negedge clk);
    bus_b.start = 1'b1; bus_b.rwb = 1'b1; bus_b.addr = 7'h5B;
    n0 = cyc;
    @(negedge clk);
    bus_b.start = 1'b0;
    low = 0; tog = 0; rises = 0; prev_s = 1'b0; prev_low = 1'b0; d = -1;
    for (int t = 0; t < 200; t++) begin
      if (!bus_b.csz) begin
        low++;
        if (prev_low && (bus_b.sclk != prev_s)) tog++;
        if (bus_b.sclk && !prev_s) rises++;
      end
      prev_low = !bus_b.csz;
      prev_s   = bus_b.sclk;
      if (bus_b.done) begin
        d = cyc;
        break;
      end
      @(negedge clk);
    end
    check("div1/csz_low", low, 49);
    check("div1/toggles", tog, 48);
    check("div1/rises", rises, 24);
    check("div1/done_cycle", d, n0 + 1 + 49 + 1);
    check("div1/rdata", bus_b.rdata, 16'hFFFF);
    check("div1/busy", bus_b.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
